// File: rtl/output_link_tx.sv
// Router output link transmitter: per-VC allocation tracking,
// on/off flow control and a registered flit stage onto the link.
package link_pkg;
  localparam int VC_SIZE_P = 1;
  localparam int DATA_W    = 32;

  typedef enum logic [1:0] {
    HEAD,
    BODY,
    TAIL,
    HEADTAIL
  } flit_label_t;

  typedef struct packed {
    flit_label_t            label;
    logic [VC_SIZE_P-1:0]   vc_id;
    logic [DATA_W-1:0]      data;
  } flit_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ALLOC,
    S_ACTIVE
  } vc_state_e;
endpackage

module output_link_tx
  import link_pkg::*;
#(
  parameter int VC_NUM  = 2,
  parameter int VC_SIZE = 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  flit_t              data_i,
  input  logic               valid_i,
  input  logic               vc_alloc_i,
  input  logic [VC_SIZE-1:0] vc_alloc_id_i,
  input  logic [VC_NUM-1:0]  on_off_i,
  output flit_t              data_o,
  output logic               valid_o,
  output logic [VC_NUM-1:0]  is_allocatable_o,
  output logic [VC_NUM-1:0]  is_on_o,
  output logic               err_o,
  output logic [CNT_W-1:0]   flit_cnt_o
);

  vc_state_e         state_q [VC_NUM];
  vc_state_e         state_d [VC_NUM];
  logic [VC_NUM-1:0] is_on_q;
  logic [VC_NUM-1:0] is_on_d;
  flit_t             data_q;
  flit_t             data_d;
  logic              valid_q;
  logic              valid_d;
  logic              err_q;
  logic              err_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic              legal;
  logic              tx;
  logic              alloc_bad;
  vc_state_e         tx_st;

  always_comb begin
    tx_st = state_q[data_i.vc_id];
    legal = 1'b0;
    unique case (1'b1)
      tx_st == S_ALLOC:
        legal = (data_i.label == HEAD) ||
                (data_i.label == HEADTAIL);
      tx_st == S_ACTIVE:
        legal = (data_i.label == BODY) ||
                (data_i.label == TAIL);
      default: legal = 1'b0;
    endcase
    tx = valid_i & is_on_q[data_i.vc_id] & legal;
    alloc_bad = vc_alloc_i &
                (state_q[vc_alloc_id_i] != S_IDLE);
  end

  // Allocation and transmit both key off the pre-edge state, so
  // a tail release and re-allocation of one VC never coincide.
  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      state_d[v] = state_q[v];
      if (tx && int'(data_i.vc_id) == v) begin
        unique case (data_i.label)
          HEAD:     state_d[v] = S_ACTIVE;
          HEADTAIL: state_d[v] = S_IDLE;
          BODY:     state_d[v] = S_ACTIVE;
          TAIL:     state_d[v] = S_IDLE;
          default:  state_d[v] = state_q[v];
        endcase
      end
      if (vc_alloc_i && int'(vc_alloc_id_i) == v &&
          state_q[v] == S_IDLE) begin
        state_d[v] = S_ALLOC;
      end
    end
  end

  always_comb begin
    is_on_d = on_off_i;
    valid_d = tx;
    data_d  = tx ? data_i : data_q;
    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, tx};
    err_d   = err_q | (valid_i & ~tx) | alloc_bad;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        state_q[v] <= S_IDLE;
      end
      is_on_q <= '1;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        state_q[v] <= state_d[v];
      end
      is_on_q <= is_on_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      is_allocatable_o[v] = (state_q[v] == S_IDLE);
    end
  end

  assign is_on_o    = is_on_q;
  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign err_o      = err_q;
  assign flit_cnt_o = cnt_q;

endmodule

// File: tb/tb_output_link_tx.sv
// Directed bench for output_link_tx: packets, flow control,
// protocol errors, async reset and counter wrap.
module tb_output_link_tx;
  import link_pkg::*;

  logic        clk;
  logic        rst;
  flit_t       data_i;
  logic        valid_i;
  logic        vc_alloc_i;
  logic [0:0]  vc_alloc_id_i;
  logic [1:0]  on_off_i;
  flit_t       data_o;
  logic        valid_o;
  logic [1:0]  alloc_o;
  logic [1:0]  is_on_o;
  logic        err_o;
  logic [15:0] cnt_o;
  flit_t       data4_o;
  logic        valid4_o;
  logic [1:0]  alloc4_o;
  logic [1:0]  is_on4_o;
  logic        err4_o;
  logic [3:0]  cnt4_o;

  int n_chk;
  int n_pass;

  output_link_tx #(.VC_NUM(2), .VC_SIZE(1), .CNT_W(16)) u_dut (
    .clk              (clk),
    .rst              (rst),
    .data_i           (data_i),
    .valid_i          (valid_i),
    .vc_alloc_i       (vc_alloc_i),
    .vc_alloc_id_i    (vc_alloc_id_i),
    .on_off_i         (on_off_i),
    .data_o           (data_o),
    .valid_o          (valid_o),
    .is_allocatable_o (alloc_o),
    .is_on_o          (is_on_o),
    .err_o            (err_o),
    .flit_cnt_o       (cnt_o)
  );

  output_link_tx #(.VC_NUM(2), .VC_SIZE(1), .CNT_W(4)) u_dut4 (
    .clk              (clk),
    .rst              (rst),
    .data_i           (data_i),
    .valid_i          (valid_i),
    .vc_alloc_i       (vc_alloc_i),
    .vc_alloc_id_i    (vc_alloc_id_i),
    .on_off_i         (on_off_i),
    .data_o           (data4_o),
    .valid_o          (valid4_o),
    .is_allocatable_o (alloc4_o),
    .is_on_o          (is_on4_o),
    .err_o            (err4_o),
    .flit_cnt_o       (cnt4_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, obs, exp);
  endtask

  function automatic flit_t mk(flit_label_t l,
                               logic v,
                               logic [31:0] d);
    flit_t f;
    f.label = l;
    f.vc_id = v;
    f.data  = d;
    return f;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    valid_i    = 1'b0;
    vc_alloc_i = 1'b0;
    data_i     = '0;
  endtask

  task automatic do_reset();
    idle_in();
    on_off_i = 2'b11;
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  task automatic alloc(input logic v);
    vc_alloc_i    = 1'b1;
    vc_alloc_id_i = v;
    cyc();
    vc_alloc_i = 1'b0;
  endtask

  task automatic send(input flit_t f);
    data_i  = f;
    valid_i = 1'b1;
    cyc();
    valid_i = 1'b0;
  endtask

  flit_t f;

  initial begin
    n_chk = 0;
    n_pass = 0;
    vc_alloc_id_i = 1'b0;
    do_reset();
    chk("rst_alloc", 64'(alloc_o), 64'h3);
    chk("rst_on", 64'(is_on_o), 64'h3);
    chk("rst_valid", 64'(valid_o), 64'h0);
    chk("rst_cnt", 64'(cnt_o), 64'h0);
    chk("rst_err", 64'(err_o), 64'h0);
    chk("rst_data", 64'(data_o), 64'h0);
    cyc();
    chk("idle_alloc", 64'(alloc_o), 64'h3);
    chk("idle_valid", 64'(valid_o), 64'h0);
    chk("idle_cnt", 64'(cnt_o), 64'h0);

    // 4-flit packet on VC 1
    alloc(1'b1);
    chk("p4_alloc", 64'(alloc_o), 64'h1);
    f = mk(HEAD, 1'b1, 32'hA1);
    send(f);
    chk("p4_h_v", 64'(valid_o), 64'h1);
    chk("p4_h_d", 64'(data_o), 64'(f));
    f = mk(BODY, 1'b1, 32'hB1);
    send(f);
    chk("p4_b1_d", 64'(data_o), 64'(f));
    f = mk(BODY, 1'b1, 32'hB2);
    send(f);
    chk("p4_b2_d", 64'(data_o), 64'(f));
    f = mk(TAIL, 1'b1, 32'hC1);
    send(f);
    chk("p4_t_v", 64'(valid_o), 64'h1);
    chk("p4_t_d", 64'(data_o), 64'(f));
    chk("p4_t_alloc", 64'(alloc_o), 64'h3);
    cyc();
    chk("p4_end_v", 64'(valid_o), 64'h0);
    chk("p4_end_hold", 64'(data_o), 64'(f));
    chk("p4_cnt", 64'(cnt_o), 64'd4);
    chk("p4_err", 64'(err_o), 64'h0);

    // single-flit packet on VC 0
    alloc(1'b0);
    chk("ht_alloc", 64'(alloc_o), 64'h2);
    f = mk(HEADTAIL, 1'b0, 32'hD0);
    send(f);
    chk("ht_v", 64'(valid_o), 64'h1);
    chk("ht_d", 64'(data_o), 64'(f));
    chk("ht_free", 64'(alloc_o), 64'h3);
    chk("ht_err", 64'(err_o), 64'h0);
    chk("ht_cnt", 64'(cnt_o), 64'd5);

    // flow control mid-packet on VC 1
    alloc(1'b1);
    send(mk(HEAD, 1'b1, 32'hE0));
    on_off_i = 2'b01;
    cyc();
    chk("fc_off", 64'(is_on_o), 64'h1);
    send(mk(BODY, 1'b1, 32'hE1));
    chk("fc_drop_v", 64'(valid_o), 64'h0);
    chk("fc_err", 64'(err_o), 64'h1);
    chk("fc_active", 64'(alloc_o), 64'h1);
    chk("fc_cnt", 64'(cnt_o), 64'd6);
    on_off_i = 2'b11;
    cyc();
    chk("fc_on", 64'(is_on_o), 64'h3);
    f = mk(TAIL, 1'b1, 32'hE2);
    send(f);
    chk("fc_t_v", 64'(valid_o), 64'h1);
    chk("fc_t_d", 64'(data_o), 64'(f));
    chk("fc_t_free", 64'(alloc_o), 64'h3);
    chk("fc_t_cnt", 64'(cnt_o), 64'd7);

    // BODY to an IDLE VC
    do_reset();
    send(mk(BODY, 1'b0, 32'h11));
    chk("e1_err", 64'(err_o), 64'h1);
    chk("e1_v", 64'(valid_o), 64'h0);
    chk("e1_alloc", 64'(alloc_o), 64'h3);

    // double allocation
    do_reset();
    alloc(1'b0);
    chk("e2_pre_err", 64'(err_o), 64'h0);
    alloc(1'b0);
    chk("e2_err", 64'(err_o), 64'h1);
    chk("e2_alloc", 64'(alloc_o), 64'h2);

    // tail release and re-allocation in one cycle
    do_reset();
    alloc(1'b0);
    send(mk(HEAD, 1'b0, 32'h21));
    f = mk(TAIL, 1'b0, 32'h22);
    data_i = f;
    valid_i = 1'b1;
    vc_alloc_i = 1'b1;
    vc_alloc_id_i = 1'b0;
    cyc();
    idle_in();
    chk("e3_v", 64'(valid_o), 64'h1);
    chk("e3_d", 64'(data_o), 64'(f));
    chk("e3_alloc", 64'(alloc_o), 64'h3);
    chk("e3_err", 64'(err_o), 64'h1);

    // async reset between edges
    do_reset();
    alloc(1'b0);
    send(mk(HEAD, 1'b0, 32'h31));
    send(mk(BODY, 1'b0, 32'h32));
    chk("ar_pre_v", 64'(valid_o), 64'h1);
    chk("ar_pre_alloc", 64'(alloc_o), 64'h2);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_v", 64'(valid_o), 64'h0);
    chk("ar_alloc", 64'(alloc_o), 64'h3);
    chk("ar_cnt", 64'(cnt_o), 64'h0);
    chk("ar_data", 64'(data_o), 64'h0);
    chk("ar_err", 64'(err_o), 64'h0);
    cyc();
    rst = 1'b1;

    // 16 flits: 4-bit counter wraps to 0
    do_reset();
    alloc(1'b0);
    send(mk(HEAD, 1'b0, 32'h40));
    for (int i = 0; i < 14; i++) begin
      send(mk(BODY, 1'b0, 32'h41 + 32'(i)));
    end
    chk("wr_cnt15", 64'(cnt4_o), 64'd15);
    send(mk(TAIL, 1'b0, 32'h4F));
    chk("wr_cnt4", 64'(cnt4_o), 64'd0);
    chk("wr_cnt16", 64'(cnt_o), 64'd16);
    chk("wr_err", 64'(err4_o), 64'h0);
    chk("wr_free", 64'(alloc4_o), 64'h3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
